uart_send_ctrl: RTL

Transmit-side controller that replays a received UART frame. It sits directly downstream of the receive controller and the byte buffer that controller fills. On the receive side's `tx_en` pulse, it latches `data_length`, reads that many bytes from the buffer starting at address 0, and hands them one at a time to the UART byte transmitter using a start/done handshake. When the frame is finished it reports completion.

---
 rtl/uart_send_ctrl_pkg.sv | 16 +
 rtl/uart_send_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/uart_send_ctrl_pkg.sv
// Shared definitions for the UART frame controllers: FSM state encodings,
// byte width and the default buffer address width.
package uart_send_ctrl_pkg;

  localparam int BYTE_W         = 8;
  localparam int ADDR_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } send_state_e;

endpackage

// File: rtl/uart_send_ctrl.sv
// Replays a buffered UART frame: fetches each byte from the buffer and hands it
// to the byte transmitter with a start/done handshake; all outputs registered.
module uart_send_ctrl
  import uart_send_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              tx_en,
  input  logic [ADDR_W-1:0] data_length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [BYTE_W-1:0] rd_data,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              send_done
);

  send_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_len_q, pend_len_d;
  logic              zhold_q, zhold_d;

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              tx_start_q, tx_start_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              send_done_q, send_done_d;

  logic [ADDR_W-1:0] start_len;
  logic              last_byte;

  assign last_byte = (idx_q == (len_q - 1'b1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    pend_d      = pend_q;
    pend_len_d  = pend_len_q;
    zhold_d     = zhold_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    send_done_d = 1'b0;
    start_len   = tx_en ? data_length : pend_len_q;

    // Requests arriving mid-frame are parked; the latest one overwrites.
    if (tx_en && (state_q != ST_IDLE)) begin
      pend_d     = 1'b1;
      pend_len_d = data_length;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_en || pend_q) begin
          pend_d = 1'b0;
          if (start_len == '0) begin
            state_d = ST_DONE;
            zhold_d = 1'b1;
          end else begin
            len_d     = start_len;
            idx_d     = '0;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tx_data_d  = rd_data;
        tx_start_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done) begin
          if (last_byte) begin
            send_done_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            idx_d     = idx_q + 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q + 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        // An empty frame lingers one extra cycle so its completion lands two
        // cycles after the request, matching the receive side's timing.
        if (zhold_q) begin
          zhold_d     = 1'b0;
          send_done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      pend_q      <= 1'b0;
      pend_len_q  <= '0;
      zhold_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      send_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      pend_q      <= pend_d;
      pend_len_q  <= pend_len_d;
      zhold_q     <= zhold_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      send_done_q <= send_done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign send_done = send_done_q;

endmodule
